sdr_cmd_fsm: RTL and testbench

SDR_CMD_FSM -- requirements
Module: sdr_cmd_fsm

---
 rtl/sdr_cmd_fsm.sv | 174 +++++++++++++++++
 tb/tb_sdr_cmd_fsm.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_cmd_fsm.sv
// SDR SDRAM command sequencer: serialises host read/write bursts and periodic
// auto-refresh into a command-state stream for the control-signal generator.
module sdr_cmd_fsm #(
  parameter int          NUM_CLK_tRCD = 2,
  parameter int          NUM_CLK_CL   = 2,
  parameter int          NUM_CLK_tRFC = 7,
  parameter int          NUM_CLK_tRP  = 2,
  parameter int          BURST_LEN    = 4,
  parameter int          REF_INTERVAL = 780,
  parameter int          RA_MSB       = 23,
  parameter int          CA_LSB       = 0,
  parameter logic [3:0]  I_READY      = 4'd8
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [3:0]         iState,
  input  logic               preq,
  input  logic               pwrite,
  input  logic [RA_MSB:CA_LSB] paddr,
  output logic [3:0]         cState,
  output logic [RA_MSB:CA_LSB] sdr_paddr,
  output logic               pack,
  output logic               rd_valid,
  output logic               wr_next,
  output logic               ref_overrun
);

  typedef enum logic [3:0] {
    c_idle   = 4'd0,
    c_ACTIVE = 4'd1,
    c_tRCD   = 4'd2,
    c_READA  = 4'd3,
    c_WRITEA = 4'd4,
    c_cl     = 4'd5,
    c_rdata  = 4'd6,
    c_wdata  = 4'd7,
    c_AR     = 4'd8,
    c_tRFC   = 4'd9
  } cmd_state_t;

  // Phase counters load "cycles - 1" and count down to 0; timing parameters
  // other than NUM_CLK_tRP must therefore be at least 1.
  localparam logic [3:0]  TRCD_LAST  = 4'(NUM_CLK_tRCD - 1);
  localparam logic [3:0]  CL_LAST    = 4'(NUM_CLK_CL - 1);
  localparam logic [3:0]  TRFC_LAST  = 4'(NUM_CLK_tRFC - 1);
  localparam logic [3:0]  BURST_LAST = 4'(BURST_LEN - 1);
  localparam logic [3:0]  WDATA_LAST = 4'((BURST_LEN > 1) ? BURST_LEN - 2 : 0);
  localparam logic [3:0]  TRP_CNT    = 4'(NUM_CLK_tRP);
  localparam logic [15:0] REF_LAST   = 16'(REF_INTERVAL - 1);

  cmd_state_t  state_reg;
  logic [3:0]  phase_cnt_reg;
  logic [3:0]  guard_cnt_reg;
  logic [15:0] ref_cnt_reg;
  logic        ref_pending_reg;
  logic        write_mode_reg;
  logic        ready;
  logic        ref_wrap;

  assign ready    = (iState == I_READY);
  assign ref_wrap = ready && (ref_cnt_reg == REF_LAST);
  assign cState   = state_reg;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg       <= c_idle;
      phase_cnt_reg   <= '0;
      guard_cnt_reg   <= '0;
      ref_cnt_reg     <= '0;
      ref_pending_reg <= 1'b0;
      write_mode_reg  <= 1'b0;
      sdr_paddr       <= '0;
      pack            <= 1'b0;
      rd_valid        <= 1'b0;
      wr_next         <= 1'b0;
      ref_overrun     <= 1'b0;
    end else begin
      if (!ready || ref_wrap) ref_cnt_reg <= '0;
      else                    ref_cnt_reg <= ref_cnt_reg + 16'd1;

      if (ref_wrap && ref_pending_reg) ref_overrun <= 1'b1;

      pack <= 1'b0;
      case (state_reg)
        c_idle: begin
          if (guard_cnt_reg != 4'd0) begin
            guard_cnt_reg <= guard_cnt_reg - 4'd1;
          end else if (ready && ref_pending_reg) begin
            state_reg       <= c_AR;
            ref_pending_reg <= 1'b0;
          end else if (ready && preq) begin
            state_reg      <= c_ACTIVE;
            pack           <= 1'b1;
            sdr_paddr      <= paddr;
            write_mode_reg <= pwrite;
          end
        end
        c_ACTIVE: begin
          state_reg     <= c_tRCD;
          phase_cnt_reg <= TRCD_LAST;
        end
        c_tRCD: begin
          if (phase_cnt_reg != 4'd0) begin
            phase_cnt_reg <= phase_cnt_reg - 4'd1;
          end else if (write_mode_reg) begin
            state_reg <= c_WRITEA;
            wr_next   <= 1'b1;
          end else begin
            state_reg <= c_READA;
          end
        end
        c_READA: begin
          state_reg     <= c_cl;
          phase_cnt_reg <= CL_LAST;
        end
        c_cl: begin
          if (phase_cnt_reg != 4'd0) begin
            phase_cnt_reg <= phase_cnt_reg - 4'd1;
          end else begin
            state_reg     <= c_rdata;
            rd_valid      <= 1'b1;
            phase_cnt_reg <= BURST_LAST;
          end
        end
        c_rdata: begin
          if (phase_cnt_reg != 4'd0) begin
            phase_cnt_reg <= phase_cnt_reg - 4'd1;
          end else begin
            state_reg     <= c_idle;
            rd_valid      <= 1'b0;
            guard_cnt_reg <= TRP_CNT;
          end
        end
        c_WRITEA: begin
          // The WRITEA cycle carries the first beat, so a one-beat burst ends here.
          if (BURST_LEN > 1) begin
            state_reg     <= c_wdata;
            phase_cnt_reg <= WDATA_LAST;
          end else begin
            state_reg     <= c_idle;
            wr_next       <= 1'b0;
            guard_cnt_reg <= TRP_CNT;
          end
        end
        c_wdata: begin
          if (phase_cnt_reg != 4'd0) begin
            phase_cnt_reg <= phase_cnt_reg - 4'd1;
          end else begin
            state_reg     <= c_idle;
            wr_next       <= 1'b0;
            guard_cnt_reg <= TRP_CNT;
          end
        end
        c_AR: begin
          state_reg     <= c_tRFC;
          phase_cnt_reg <= TRFC_LAST;
        end
        c_tRFC: begin
          if (phase_cnt_reg != 4'd0) phase_cnt_reg <= phase_cnt_reg - 4'd1;
          else                       state_reg     <= c_idle;
        end
        default: begin
          state_reg <= c_idle;
          rd_valid  <= 1'b0;
          wr_next   <= 1'b0;
        end
      endcase

      // A new expiry wins over the clear issued on entry to c_AR.
      if (ref_wrap) ref_pending_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdr_cmd_fsm.sv
// Scoreboard bench for sdr_cmd_fsm: stimulus queues expected command traces and
// acceptances, a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_sdr_cmd_fsm;

  localparam int         AW    = 24;
  localparam logic [3:0] I_RDY = 4'd8;
  localparam logic [3:0] I_NOT = 4'd3;
  localparam logic [3:0] S_IDLE = 4'd0, S_ACT = 4'd1, S_TRCD = 4'd2, S_READA = 4'd3,
                         S_WRITEA = 4'd4, S_CL = 4'd5, S_RDATA = 4'd6, S_WDATA = 4'd7,
                         S_AR = 4'd8, S_TRFC = 4'd9;

  typedef struct packed {
    int         cyc;
    logic [3:0] st;
    logic       pk;
    logic       rv;
    logic       wn;
  } trc_t;

  typedef struct packed {
    int            cyc;
    logic [AW-1:0] addr;
    logic          wr;
  } acc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          presetn;
  logic [3:0]    istate;
  logic          preq, pwrite;
  logic [AW-1:0] paddr;
  logic [3:0]    cstate;
  logic [AW-1:0] sdr_paddr;
  logic          pack, rd_valid, wr_next, ref_overrun;

  logic          aux_rstn;
  logic [3:0]    r8_cstate, ov_cstate;
  logic [AW-1:0] r8_addr, ov_addr;
  logic          r8_pack, r8_rv, r8_wn, r8_ovr;
  logic          ov_pack, ov_rv, ov_wn, ov_ovr;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  trc_t trc_q[$];
  acc_t acc_q[$];

  sdr_cmd_fsm #(.RA_MSB(AW-1), .CA_LSB(0)) u_dut (
    .pclk(clk), .presetn(presetn), .iState(istate), .preq(preq), .pwrite(pwrite),
    .paddr(paddr), .cState(cstate), .sdr_paddr(sdr_paddr), .pack(pack),
    .rd_valid(rd_valid), .wr_next(wr_next), .ref_overrun(ref_overrun)
  );

  sdr_cmd_fsm #(.REF_INTERVAL(8), .RA_MSB(AW-1), .CA_LSB(0)) u_r8 (
    .pclk(clk), .presetn(aux_rstn), .iState(I_RDY), .preq(1'b1), .pwrite(1'b1),
    .paddr(24'h0A0A0A), .cState(r8_cstate), .sdr_paddr(r8_addr), .pack(r8_pack),
    .rd_valid(r8_rv), .wr_next(r8_wn), .ref_overrun(r8_ovr)
  );

  sdr_cmd_fsm #(.REF_INTERVAL(8), .NUM_CLK_tRFC(15), .RA_MSB(AW-1), .CA_LSB(0)) u_ov (
    .pclk(clk), .presetn(aux_rstn), .iState(I_RDY), .preq(1'b1), .pwrite(1'b1),
    .paddr(24'h0B0B0B), .cState(ov_cstate), .sdr_paddr(ov_addr), .pack(ov_pack),
    .rd_valid(ov_rv), .wr_next(ov_wn), .ref_overrun(ov_ovr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_st(input int c, input logic [3:0] s, input logic pk, input logic rv,
                        input logic wn);
    trc_t t;
    t.cyc = c; t.st = s; t.pk = pk; t.rv = rv; t.wn = wn;
    trc_q.push_back(t);
  endtask

  task automatic exp_acc(input int c, input logic [AW-1:0] a, input logic wr);
    acc_t e;
    e.cyc = c; e.addr = a; e.wr = wr;
    acc_q.push_back(e);
  endtask

  // Read accepted from an idle cycle b: trace through the two guard cycles.
  task automatic push_read(input int b);
    exp_st(b, S_IDLE, 0, 0, 0);
    exp_st(b + 1, S_ACT, 1, 0, 0);
    exp_st(b + 2, S_TRCD, 0, 0, 0);
    exp_st(b + 3, S_TRCD, 0, 0, 0);
    exp_st(b + 4, S_READA, 0, 0, 0);
    exp_st(b + 5, S_CL, 0, 0, 0);
    exp_st(b + 6, S_CL, 0, 0, 0);
    for (int i = 7; i <= 10; i++) exp_st(b + i, S_RDATA, 0, 1, 0);
    exp_st(b + 11, S_IDLE, 0, 0, 0);
    exp_st(b + 12, S_IDLE, 0, 0, 0);
  endtask

  task automatic push_write(input int b);
    exp_st(b, S_IDLE, 0, 0, 0);
    exp_st(b + 1, S_ACT, 1, 0, 0);
    exp_st(b + 2, S_TRCD, 0, 0, 0);
    exp_st(b + 3, S_TRCD, 0, 0, 0);
    exp_st(b + 4, S_WRITEA, 0, 0, 1);
    for (int i = 5; i <= 7; i++) exp_st(b + i, S_WDATA, 0, 0, 1);
    exp_st(b + 8, S_IDLE, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cstate"}, 64'(cstate), 64'(S_IDLE));
    check({tag, "_sdr_paddr"}, 64'(sdr_paddr), 64'd0);
    check({tag, "_pack"}, 64'(pack), 64'd0);
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_wr_next"}, 64'(wr_next), 64'd0);
    check({tag, "_ref_overrun"}, 64'(ref_overrun), 64'd0);
  endtask

  // Monitor: trace scoreboard, acceptance scoreboard, per-burst beat count.
  trc_t mon_t;
  acc_t mon_a;
  logic inflight = 1'b0;
  logic cur_wr   = 1'b0;
  int   rbeats   = 0;
  int   wbeats   = 0;

  always @(negedge clk) begin
    if (!presetn) begin
      inflight = 1'b0;
    end else begin
      while (trc_q.size() > 0 && trc_q[0].cyc <= cyc) begin
        mon_t = trc_q.pop_front();
        check($sformatf("trace@%0d", mon_t.cyc),
              {32'(cyc), 25'd0, cstate, pack, rd_valid, wr_next},
              {32'(mon_t.cyc), 25'd0, mon_t.st, mon_t.pk, mon_t.rv, mon_t.wn});
      end
      if (pack) begin
        if (acc_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_pack: got pack=1 addr=%h, expected no acceptance (cycle %0d)",
                   sdr_paddr, cyc);
        end else begin
          mon_a = acc_q.pop_front();
          check("acc_cycle", 64'(cyc), 64'(mon_a.cyc));
          check("acc_addr", 64'(sdr_paddr), 64'(mon_a.addr));
          $display("accept cyc=%0d addr=%h write=%0b", cyc, sdr_paddr, mon_a.wr);
          inflight = 1'b1;
          cur_wr   = mon_a.wr;
          rbeats   = 0;
          wbeats   = 0;
        end
      end
      if (inflight) begin
        rbeats += int'(rd_valid);
        wbeats += int'(wr_next);
        if (cstate == S_IDLE) begin
          check("beats", {32'(rbeats), 32'(wbeats)}, cur_wr ? {32'd0, 32'd4} : {32'd4, 32'd0});
          inflight = 1'b0;
        end
      end
    end
  end

  int r8_ar = 0;
  int r8_pk = 0;
  always @(negedge clk) begin
    if (aux_rstn) begin
      if (r8_cstate == S_AR) r8_ar++;
      if (r8_pack) r8_pk++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, r, s, s2, b;
    presetn = 1'b0; aux_rstn = 1'b0;
    istate = I_NOT; preq = 1'b0; pwrite = 1'b0; paddr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    presetn = 1'b1;

    // Requests while the init FSM is not ready are ignored.
    n = cyc + 1;
    wait_cyc(n);
    preq = 1'b1; pwrite = 1'b0; paddr = 24'h111111;
    for (int i = 0; i < 6; i++) exp_st(n + i, S_IDLE, 0, 0, 0);
    r = n + 6;
    push_read(r);
    push_write(r + 13);
    exp_acc(r + 1, 24'h123456, 1'b0);
    exp_acc(r + 14, 24'h654321, 1'b1);

    // Read at cycle r; a write held from the guard window waits for it to expire.
    wait_cyc(r);
    istate = I_RDY; preq = 1'b1; pwrite = 1'b0; paddr = 24'h123456;
    wait_cyc(r + 1);
    preq = 1'b0; paddr = 24'hDEAD00;
    wait_cyc(r + 11);
    preq = 1'b1; pwrite = 1'b1; paddr = 24'h654321;
    wait_cyc(r + 14);
    preq = 1'b0;

    // First refresh expiry coincides with a request; refresh goes first.
    wait_cyc(r + 780);
    exp_st(r + 780, S_IDLE, 0, 0, 0);
    exp_st(r + 781, S_AR, 0, 0, 0);
    for (int i = 782; i <= 788; i++) exp_st(r + i, S_TRFC, 0, 0, 0);
    push_read(r + 789);
    exp_acc(r + 790, 24'hA4A4A4, 1'b0);
    preq = 1'b1; pwrite = 1'b0; paddr = 24'hA3A3A3;
    wait_cyc(r + 783);
    paddr = 24'hA4A4A4;
    wait_cyc(r + 790);
    preq = 1'b0;

    // Asynchronous reset during CAS latency.
    s = r + 805;
    wait_cyc(s);
    exp_st(s, S_IDLE, 0, 0, 0);
    exp_st(s + 1, S_ACT, 1, 0, 0);
    exp_st(s + 2, S_TRCD, 0, 0, 0);
    exp_st(s + 3, S_TRCD, 0, 0, 0);
    exp_st(s + 4, S_READA, 0, 0, 0);
    exp_acc(s + 1, 24'h5A5A5A, 1'b0);
    preq = 1'b1; pwrite = 1'b0; paddr = 24'h5A5A5A;
    wait_cyc(s + 1);
    preq = 1'b0;
    wait_cyc(s + 5);
    #2;
    presetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    presetn = 1'b1;
    s2 = cyc + 2;
    wait_cyc(s2);
    push_read(s2);
    exp_acc(s2 + 1, 24'h6B6B6B, 1'b0);
    preq = 1'b1; pwrite = 1'b0; paddr = 24'h6B6B6B;
    wait_cyc(s2 + 1);
    preq = 1'b0;
    wait_cyc(s2 + 14);
    check("acc_queue_drained", 64'(acc_q.size()), 64'd0);
    check("trace_queue_drained", 64'(trc_q.size()), 64'd0);

    // Short refresh interval with a continuously held write request.
    @(negedge clk);
    aux_rstn = 1'b1;
    b = cyc;
    wait_cyc(b + 21);
    check("ov_overrun_early", 64'(ov_ovr), 64'd0);
    wait_cyc(b + 53);
    check("r8_refresh_count", 64'(r8_ar), 64'd5);
    check("r8_accept_count", 64'(r8_pk), 64'd1);
    check("r8_overrun", 64'(r8_ovr), 64'd0);
    check("ov_overrun_late", 64'(ov_ovr), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
